// File: rtl/vm_change_dispenser.sv
// Coin-return unit: pays a requested amount one coin at a time through an acked hopper,
// preferring 1000-won coins, falling back to 500-won coins, and tracking both inventories.
module vm_change_dispenser #(
    parameter int AMT_W       = 16,
    parameter int MAX_AMOUNT  = 5000,
    parameter int INV_W       = 8,
    parameter int INIT_1000   = 20,
    parameter int INIT_500    = 20,
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_req,
    input  logic [AMT_W-1:0] change_amount,
    input  logic             refill_1000,
    input  logic             refill_500,
    input  logic             hop_ack,
    output logic             coin_1000,
    output logic             coin_500,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv_1000,
    output logic [INV_W-1:0] inv_500
);

    // Inventory value needs headroom for 1000 * (2^INV_W-1) plus the 500 term.
    localparam int SUM_W = AMT_W + INV_W + 11;
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    logic             r_coin_1000;
    logic             r_coin_500;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [AMT_W-1:0] r_remaining;
    logic [INV_W-1:0] r_inv_1000;
    logic [INV_W-1:0] r_inv_500;
    logic             r_sel_1000;
    logic [TMR_W-1:0] r_timer;
    logic [GAP_W-1:0] r_gap;

    logic [SUM_W-1:0] w_inv_value;
    logic             w_illegal;
    logic             w_short;
    logic             w_use_1000;
    logic             w_dec_1000;
    logic             w_dec_500;
    logic [AMT_W-1:0] w_coin_val;

    assign w_inv_value = SUM_W'(r_inv_1000) * SUM_W'(1000) + SUM_W'(r_inv_500) * SUM_W'(500);

    assign w_illegal = ((change_amount % AMT_W'(500)) != '0) ||
                       (change_amount > AMT_W'(MAX_AMOUNT));

    // An odd 500 can only be paid with a 500 coin, so the value total alone is not enough.
    assign w_short = (SUM_W'(change_amount) > w_inv_value) ||
                     (((change_amount % AMT_W'(1000)) != '0) && (r_inv_500 == '0));

    assign w_use_1000 = (r_remaining >= AMT_W'(1000)) && (r_inv_1000 != '0);
    assign w_dec_1000 = (r_state == S_ISSUE) && w_use_1000;
    assign w_dec_500  = (r_state == S_ISSUE) && !w_use_1000;
    assign w_coin_val = r_sel_1000 ? AMT_W'(1000) : AMT_W'(500);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_coin_1000 <= 1'b0;
            r_coin_500  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_remaining <= '0;
            r_sel_1000  <= 1'b0;
            r_timer     <= '0;
            r_gap       <= '0;
        end else begin
            r_coin_1000 <= 1'b0;
            r_coin_500  <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (change_req) begin
                        r_remaining <= change_amount;
                        r_err       <= 1'b0;
                        r_err_code  <= 2'd0;
                        r_busy      <= 1'b1;
                        if (change_amount == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_illegal) begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= 2'd1;
                        end else if (w_short) begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= 2'd2;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_sel_1000  <= w_use_1000;
                    r_coin_1000 <= w_use_1000;
                    r_coin_500  <= !w_use_1000;
                    r_timer     <= '0;
                    r_state     <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (hop_ack) begin
                        r_remaining <= r_remaining - w_coin_val;
                        if (r_remaining == w_coin_val) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end
                    end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        // Jammed coin: it stays owed and stays deducted from inventory.
                        r_state    <= S_ERR;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A refill landing on the same cycle as an issue of that coin cancels it out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inv_1000 <= INV_W'(INIT_1000);
            r_inv_500  <= INV_W'(INIT_500);
        end else begin
            if (w_dec_1000 && refill_1000) begin
                r_inv_1000 <= r_inv_1000;
            end else if (w_dec_1000) begin
                r_inv_1000 <= r_inv_1000 - 1'b1;
            end else if (refill_1000 && (r_inv_1000 != '1)) begin
                r_inv_1000 <= r_inv_1000 + 1'b1;
            end

            if (w_dec_500 && refill_500) begin
                r_inv_500 <= r_inv_500;
            end else if (w_dec_500) begin
                r_inv_500 <= r_inv_500 - 1'b1;
            end else if (refill_500 && (r_inv_500 != '1)) begin
                r_inv_500 <= r_inv_500 + 1'b1;
            end
        end
    end

    assign coin_1000 = r_coin_1000;
    assign coin_500  = r_coin_500;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign remaining = r_remaining;
    assign inv_1000  = r_inv_1000;
    assign inv_500   = r_inv_500;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench: three dispenser instances with different starting inventories,
// one task per scenario, hand-computed expectations checked inline.
module tb_vm_change_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  ack = '0;
    logic [2:0]  rf1 = '0;
    logic [2:0]  rf5 = '0;
    logic [15:0] amt [3];
    logic [2:0]  c1, c5, bsy, dn, er;
    logic [1:0]  code [3];
    logic [15:0] rem [3];
    logic [7:0]  inv1 [3];
    logic [7:0]  inv5 [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vm_change_dispenser dut0 (
        .clk(clk), .reset(reset), .change_req(req[0]), .change_amount(amt[0]),
        .refill_1000(rf1[0]), .refill_500(rf5[0]), .hop_ack(ack[0]),
        .coin_1000(c1[0]), .coin_500(c5[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]),
        .err_code(code[0]), .remaining(rem[0]), .inv_1000(inv1[0]), .inv_500(inv5[0]));

    vm_change_dispenser #(.INIT_1000(1)) dut1 (
        .clk(clk), .reset(reset), .change_req(req[1]), .change_amount(amt[1]),
        .refill_1000(rf1[1]), .refill_500(rf5[1]), .hop_ack(ack[1]),
        .coin_1000(c1[1]), .coin_500(c5[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]),
        .err_code(code[1]), .remaining(rem[1]), .inv_1000(inv1[1]), .inv_500(inv5[1]));

    vm_change_dispenser #(.INIT_1000(1), .INIT_500(1)) dut2 (
        .clk(clk), .reset(reset), .change_req(req[2]), .change_amount(amt[2]),
        .refill_1000(rf1[2]), .refill_500(rf5[2]), .hop_ack(ack[2]),
        .coin_1000(c1[2]), .coin_500(c5[2]), .busy(bsy[2]), .done(dn[2]), .err(er[2]),
        .err_code(code[2]), .remaining(rem[2]), .inv_1000(inv1[2]), .inv_500(inv5[2]));

    // Issues one request and shepherds it until busy drops. Coin order is packed two bits
    // per coin (1 = 1000, 2 = 500); gap is cycles between the first two coin pulses;
    // t_err is cycles from the last coin pulse to err rising; ack_dly < 0 means never ack.
    task automatic run_txn(input int d, input logic [15:0] a, input int ack_dly,
                           input int req_hold, input bit stop_at_coin,
                           output int n1, output int n5, output int order, output int ndone,
                           output int both, output int gap, output int t_err, output bit tmo);
        int cd;
        int last_coin;
        n1 = 0; n5 = 0; order = 0; ndone = 0; both = 0;
        gap = -1; t_err = -1; tmo = 1'b1; cd = -1; last_coin = -1;
        @(negedge clk);
        amt[d] = a;
        req[d] = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (cyc >= req_hold) req[d] = 1'b0;
            ack[d] = 1'b0;
            if (c1[d] || c5[d]) begin
                if (c1[d] && c5[d]) both++;
                if (c1[d]) begin n1++; order = (order << 2) | 1; end
                if (c5[d]) begin n5++; order = (order << 2) | 2; end
                if (last_coin >= 0 && gap < 0) gap = cyc - last_coin;
                last_coin = cyc;
                cd = ack_dly;
                if (stop_at_coin) begin tmo = 1'b0; break; end
            end
            if (er[d] && t_err < 0 && last_coin >= 0) t_err = cyc - last_coin;
            if (dn[d]) ndone++;
            if (cd == 0) begin ack[d] = 1'b1; cd = -1; end
            else if (cd > 0) cd--;
            if (!bsy[d]) begin tmo = 1'b0; break; end
        end
        req[d] = 1'b0;
        ack[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({c1[0], c5[0], bsy[0], dn[0], er[0]} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b want 00000", {c1[0], c5[0], bsy[0], dn[0], er[0]});
        end
        tests++;
        if (code[0] !== 2'd0 || rem[0] !== 16'd0) begin
            fails++; $display("FAIL reset_code_rem got code=%0d rem=%0d want 0 0", code[0], rem[0]);
        end
        tests++;
        if (inv1[0] !== 8'd20 || inv5[0] !== 8'd20) begin
            fails++; $display("FAIL reset_inv got %0d/%0d want 20/20", inv1[0], inv5[0]);
        end
        tests++;
        if (inv1[2] !== 8'd1 || inv5[2] !== 8'd1 || inv1[1] !== 8'd1) begin
            fails++; $display("FAIL reset_inv_param got d1=%0d d2=%0d/%0d want 1 1/1", inv1[1], inv1[2], inv5[2]);
        end
        reset = 1'b0;
    endtask

    task automatic test_greedy_2500();
        int n1, n5, ord, nd, bo, gp, te; bit to;
        run_txn(0, 16'd2500, 3, 0, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
        tests++;
        if (to !== 1'b0) begin fails++; $display("FAIL greedy_timeout got %0d want 0", to); end
        tests++;
        if (ord !== 22 || n1 !== 2 || n5 !== 1) begin
            fails++; $display("FAIL greedy_order got ord=%0d n1=%0d n5=%0d want 22 2 1", ord, n1, n5);
        end
        tests++;
        if (gp !== 7) begin fails++; $display("FAIL greedy_gap got %0d want 7", gp); end
        tests++;
        if (nd !== 1 || bo !== 0 || rem[0] !== 16'd0 || er[0] !== 1'b0) begin
            fails++; $display("FAIL greedy_done got done=%0d both=%0d rem=%0d err=%0d want 1 0 0 0", nd, bo, rem[0], er[0]);
        end
        tests++;
        if (inv1[0] !== 8'd18 || inv5[0] !== 8'd19) begin
            fails++; $display("FAIL greedy_inv got %0d/%0d want 18/19", inv1[0], inv5[0]);
        end
    endtask

    task automatic test_fallback();
        int n1, n5, ord, nd, bo, gp, te; bit to;
        run_txn(1, 16'd2000, 0, 0, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
        tests++;
        if (to !== 1'b0 || ord !== 26 || n1 !== 1 || n5 !== 2) begin
            fails++; $display("FAIL fallback_order got to=%0d ord=%0d n1=%0d n5=%0d want 0 26 1 2", to, ord, n1, n5);
        end
        tests++;
        if (gp !== 4 || nd !== 1 || bo !== 0) begin
            fails++; $display("FAIL fallback_timing got gap=%0d done=%0d both=%0d want 4 1 0", gp, nd, bo);
        end
        tests++;
        if (inv1[1] !== 8'd0 || inv5[1] !== 8'd18 || rem[1] !== 16'd0) begin
            fails++; $display("FAIL fallback_inv got %0d/%0d rem=%0d want 0/18 0", inv1[1], inv5[1], rem[1]);
        end
    endtask

    task automatic test_illegal();
        int n1, n5, ord, nd, bo, gp, te; bit to;
        logic [15:0] bad [2];
        bad[0] = 16'd1200;
        bad[1] = 16'd5500;
        for (int i = 0; i < 2; i++) begin
            run_txn(0, bad[i], 0, 0, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
            tests++;
            if (to !== 1'b0 || er[0] !== 1'b1 || code[0] !== 2'd1) begin
                fails++; $display("FAIL illegal_%0d got to=%0d err=%0d code=%0d want 0 1 1", bad[i], to, er[0], code[0]);
            end
            tests++;
            if (n1 + n5 !== 0 || nd !== 0 || inv1[0] !== 8'd18 || inv5[0] !== 8'd19 || rem[0] !== bad[i]) begin
                fails++; $display("FAIL illegal_side_%0d got coins=%0d done=%0d inv=%0d/%0d rem=%0d want 0 0 18/19 %0d",
                                  bad[i], n1 + n5, nd, inv1[0], inv5[0], rem[0], bad[i]);
            end
        end
        run_txn(0, 16'd500, 1, 0, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
        tests++;
        if (to !== 1'b0 || er[0] !== 1'b0 || code[0] !== 2'd0 || ord !== 2 || nd !== 1) begin
            fails++; $display("FAIL recover_500 got to=%0d err=%0d code=%0d ord=%0d done=%0d want 0 0 0 2 1",
                              to, er[0], code[0], ord, nd);
        end
        tests++;
        if (inv1[0] !== 8'd18 || inv5[0] !== 8'd18) begin
            fails++; $display("FAIL recover_inv got %0d/%0d want 18/18", inv1[0], inv5[0]);
        end
        run_txn(0, 16'd0, 0, 0, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
        tests++;
        if (to !== 1'b0 || nd !== 1 || n1 + n5 !== 0 || er[0] !== 1'b0) begin
            fails++; $display("FAIL zero_amount got to=%0d done=%0d coins=%0d err=%0d want 0 1 0 0", to, nd, n1 + n5, er[0]);
        end
    endtask

    task automatic test_insufficient();
        int n1, n5, ord, nd, bo, gp, te; bit to;
        run_txn(2, 16'd2000, 0, 0, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
        tests++;
        if (to !== 1'b0 || er[2] !== 1'b1 || code[2] !== 2'd2 || n1 + n5 !== 0) begin
            fails++; $display("FAIL short_2000 got to=%0d err=%0d code=%0d coins=%0d want 0 1 2 0", to, er[2], code[2], n1 + n5);
        end
        tests++;
        if (inv1[2] !== 8'd1 || inv5[2] !== 8'd1) begin
            fails++; $display("FAIL short_inv got %0d/%0d want 1/1", inv1[2], inv5[2]);
        end
        // Exactly the whole inventory is still payable.
        run_txn(2, 16'd1500, 0, 0, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
        tests++;
        if (to !== 1'b0 || er[2] !== 1'b0 || ord !== 6 || nd !== 1 || inv1[2] !== 8'd0 || inv5[2] !== 8'd0) begin
            fails++; $display("FAIL exact_1500 got to=%0d err=%0d ord=%0d done=%0d inv=%0d/%0d want 0 0 6 1 0/0",
                              to, er[2], ord, nd, inv1[2], inv5[2]);
        end
    endtask

    task automatic test_timeout();
        int n1, n5, ord, nd, bo, gp, te; bit to;
        // change_req held through the first 100 busy cycles must be ignored.
        run_txn(0, 16'd1000, -1, 100, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
        tests++;
        if (to !== 1'b0 || n1 !== 1 || n5 !== 0 || nd !== 0) begin
            fails++; $display("FAIL timeout_coins got to=%0d n1=%0d n5=%0d done=%0d want 0 1 0 0", to, n1, n5, nd);
        end
        tests++;
        if (te !== 255 || er[0] !== 1'b1 || code[0] !== 2'd3) begin
            fails++; $display("FAIL timeout_err got cycles=%0d err=%0d code=%0d want 255 1 3", te, er[0], code[0]);
        end
        tests++;
        if (rem[0] !== 16'd1000 || inv1[0] !== 8'd17 || inv5[0] !== 8'd18) begin
            fails++; $display("FAIL timeout_state got rem=%0d inv=%0d/%0d want 1000 17/18", rem[0], inv1[0], inv5[0]);
        end
        @(negedge clk); ack[0] = 1'b1;
        @(negedge clk); ack[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (rem[0] !== 16'd1000 || c1[0] !== 1'b0 || c5[0] !== 1'b0 || bsy[0] !== 1'b0 ||
            er[0] !== 1'b1 || code[0] !== 2'd3) begin
            fails++; $display("FAIL idle_ack got rem=%0d coins=%b busy=%0d err=%0d code=%0d want 1000 00 0 1 3",
                              rem[0], {c1[0], c5[0]}, bsy[0], er[0], code[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n1, n5, ord, nd, bo, gp, te; bit to;
        run_txn(0, 16'd3000, -1, 0, 1'b1, n1, n5, ord, nd, bo, gp, te, to);
        tests++;
        if (to !== 1'b0 || n1 !== 1 || bsy[0] !== 1'b1) begin
            fails++; $display("FAIL mid_setup got to=%0d n1=%0d busy=%0d want 0 1 1", to, n1, bsy[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({c1[0], c5[0], bsy[0], dn[0], er[0]} !== 5'b0 || code[0] !== 2'd0 || rem[0] !== 16'd0) begin
            fails++; $display("FAIL mid_reset got flags=%b code=%0d rem=%0d want 00000 0 0",
                              {c1[0], c5[0], bsy[0], dn[0], er[0]}, code[0], rem[0]);
        end
        tests++;
        if (inv1[0] !== 8'd20 || inv5[0] !== 8'd20 || inv1[1] !== 8'd1 || inv5[1] !== 8'd20) begin
            fails++; $display("FAIL mid_inv got %0d/%0d d1=%0d/%0d want 20/20 1/20", inv1[0], inv5[0], inv1[1], inv5[1]);
        end
    endtask

    task automatic test_refill();
        int n1, n5, ord, nd, bo, gp, te; bit to;
        rf5[0] = 1'b1;
        repeat (300) @(negedge clk);
        rf5[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (inv5[0] !== 8'd255 || inv1[0] !== 8'd20) begin
            fails++; $display("FAIL refill_sat got %0d/%0d want 20/255", inv1[0], inv5[0]);
        end
        // Refill held through a 500 payout: the issue cycle nets to zero, others saturate.
        rf5[0] = 1'b1;
        run_txn(0, 16'd500, 0, 0, 1'b0, n1, n5, ord, nd, bo, gp, te, to);
        rf5[0] = 1'b0;
        tests++;
        if (to !== 1'b0 || n5 !== 1 || nd !== 1 || inv5[0] !== 8'd255) begin
            fails++; $display("FAIL refill_issue got to=%0d n5=%0d done=%0d inv500=%0d want 0 1 1 255", to, n5, nd, inv5[0]);
        end
    endtask

    initial begin
        amt[0] = '0; amt[1] = '0; amt[2] = '0;
        test_reset();
        test_greedy_2500();
        test_fallback();
        test_illegal();
        test_insufficient();
        test_timeout();
        test_reset_mid();
        test_refill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
